// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin 4:1 packet arbiter with a single-entry registered output stage.
// Optional stall watchdog: define MUX_ARB_WATCHDOG_EN.
module mux4_rr_arbiter #(
  parameter int DW          = 32,
  parameter int WDOG_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req_valid,
  input  logic [4*DW-1:0] req_data,
  input  logic [3:0]      req_last,
  output logic [3:0]      req_ready,
  output logic [1:0]      sel,
  output logic            busy,
  output logic            m_valid,
  output logic [DW-1:0]   m_data,
  output logic            m_last,
  input  logic            m_ready,
  output logic            wdog_err
);

  // Handshake: a beat moves on any rising edge where valid and ready are both high;
  // ready never depends on the same port's valid, and a producer holds data/last until accepted.
  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [1:0]    ptr;
  logic [1:0]    winner;
  logic [DW-1:0] lane [4];
  logic          can_load;
  logic          sel_valid;
  logic          xfer;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    assign lane[i] = req_data[i*DW +: DW];
  end

  // Walk the search order backwards so the entry closest to ptr is written last and wins.
  always_comb begin
    winner = ptr;
    for (int k = 3; k >= 0; k--) begin
      if (req_valid[ptr + 2'(k)]) winner = ptr + 2'(k);
    end
  end

  assign can_load  = ~m_valid | m_ready;
  assign sel_valid = req_valid[sel];
  assign xfer      = (state == GRANT) & sel_valid & can_load;

  always_comb begin
    req_ready = '0;
    if (state == GRANT) req_ready[sel] = can_load;
  end

`ifdef MUX_ARB_WATCHDOG_EN
  localparam int WCW = $clog2(WDOG_CYCLES + 1);
  logic [WCW-1:0] wdog_cnt;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sel      <= 2'd0;
      busy     <= 1'b0;
      ptr      <= 2'd0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_last   <= 1'b0;
`ifdef MUX_ARB_WATCHDOG_EN
      wdog_err <= 1'b0;
      wdog_cnt <= '0;
`endif
    end else begin
      if (xfer) begin
        m_valid <= 1'b1;
        m_data  <= lane[sel];
        m_last  <= req_last[sel];
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
`ifdef MUX_ARB_WATCHDOG_EN
      wdog_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
`ifdef MUX_ARB_WATCHDOG_EN
          wdog_cnt <= '0;
`endif
          if (|req_valid) begin
            sel   <= winner;
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (xfer && req_last[sel]) begin
            state <= IDLE;
            busy  <= 1'b0;
            ptr   <= sel + 2'd1;
          end
`ifdef MUX_ARB_WATCHDOG_EN
          // Only a silent granted requester ages the counter; a downstream stall does not.
          if (sel_valid) begin
            wdog_cnt <= '0;
          end else if (wdog_cnt == WCW'(WDOG_CYCLES - 1)) begin
            wdog_cnt <= '0;
            wdog_err <= 1'b1;
            state    <= IDLE;
            busy     <= 1'b0;
            ptr      <= sel + 2'd1;
          end else begin
            wdog_cnt <= wdog_cnt + 1'b1;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef MUX_ARB_WATCHDOG_EN
  assign wdog_err = (WDOG_CYCLES < 0);
`endif

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: arbitration order, packet lock, stalls, reset and watchdog.
module tb_mux4_rr_arbiter;
  localparam int DW = 32;
`ifdef MUX_ARB_WATCHDOG_EN
  localparam int WD = 4;
`else
  localparam int WD = 16;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic [3:0]      req_valid;
  logic [4*DW-1:0] req_data;
  logic [3:0]      req_last;
  logic [3:0]      req_ready;
  logic [1:0]      sel;
  logic            busy;
  logic            m_valid;
  logic [DW-1:0]   m_data;
  logic            m_last;
  logic            m_ready;
  logic            wdog_err;

  int total = 0;
  int bad   = 0;

  mux4_rr_arbiter #(.DW(DW), .WDOG_CYCLES(WD)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .sel(sel), .busy(busy),
    .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
    .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int i, input logic [DW-1:0] d, input logic l);
    req_data[i*DW +: DW] = d;
    req_last[i]          = l;
  endtask

  // Requester obligation: data/last stable while valid is high and not yet accepted.
  logic [3:0]    pv, pr, pl;
  logic [DW-1:0] pd [4];
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst_n && pv[i] && !pr[i] && req_valid[i]) begin
        total++;
        assert (pd[i] === req_data[i*DW +: DW] && pl[i] === req_last[i]) else begin
          bad++;
          $error("FAIL stable_lane%0d observed=%0h expected=%0h", i, req_data[i*DW +: DW], pd[i]);
        end
      end
      pd[i] <= req_data[i*DW +: DW];
    end
    pv <= req_valid;
    pr <= req_ready;
    pl <= req_last;
  end

  initial begin
    rst_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; m_ready = 1'b1;
    pv = '0; pr = '0; pl = '0;
    repeat (3) tick();
    chk("rst_sel", 64'(sel), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_m_valid", 64'(m_valid), 0);
    chk("rst_m_data", 64'(m_data), 0);
    chk("rst_m_last", 64'(m_last), 0);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_wdog", 64'(wdog_err), 0);
    rst_n = 1'b1;
    tick();

    // Two-beat packet on requester 2.
    req_valid = 4'b0100; set_lane(2, 32'hAAAA0001, 1'b0);
    #1 chk("t1_idle_ready", 64'(req_ready), 0);
    tick();
    chk("t1_sel", 64'(sel), 2);
    chk("t1_busy", 64'(busy), 1);
    chk("t1_no_data_yet", 64'(m_valid), 0);
    chk("t1_ready", 64'(req_ready), 4'b0100);
    tick();
    chk("t1_beat1_valid", 64'(m_valid), 1);
    chk("t1_beat1_data", 64'(m_data), 32'hAAAA0001);
    chk("t1_beat1_last", 64'(m_last), 0);
    set_lane(2, 32'hAAAA0002, 1'b1);
    tick();
    req_valid = 4'b0000;
    chk("t1_beat2_data", 64'(m_data), 32'hAAAA0002);
    chk("t1_beat2_last", 64'(m_last), 1);
    chk("t1_busy_drop", 64'(busy), 0);
    chk("t1_sel_hold", 64'(sel), 2);
    tick();
    chk("t1_drained", 64'(m_valid), 0);
    // ptr is now 3: requester 3 beats requester 0.
    req_valid = 4'b1001; set_lane(3, 32'h3333_0000, 1'b1); set_lane(0, 32'h0, 1'b1);
    tick();
    chk("t1_ptr3_sel", 64'(sel), 3);
    tick();
    req_valid = 4'b0000;
    chk("t1_ptr3_data", 64'(m_data), 32'h3333_0000);
    tick();

    // All four requesting single-beat packets: order 0,1,2,3,0.
    for (int i = 0; i < 4; i++) set_lane(i, 32'h1000_0000 + 32'(i), 1'b1);
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      tick();
      chk("t2_sel", 64'(sel), 64'(n % 4));
      chk("t2_busy", 64'(busy), 1);
      chk("t2_onehot", 64'(req_ready), 64'(4'b0001 << (n % 4)));
      tick();
      chk("t2_data", 64'(m_data), 64'(32'h1000_0000 + 32'(n % 4)));
      chk("t2_idle", 64'(busy), 0);
      chk("t2_idle_ready", 64'(req_ready), 0);
    end
    req_valid = 4'b0000;
    tick(); tick();
    chk("t2_drained", 64'(m_valid), 0);

    // Requester 1: three beats with a 5-cycle downstream stall after beat 1.
    req_valid = 4'b0010; set_lane(1, 32'hB000_0001, 1'b0);
    tick();
    chk("t3_sel", 64'(sel), 1);
    tick();
    chk("t3_b1", 64'(m_data), 32'hB000_0001);
    set_lane(1, 32'hB000_0002, 1'b0); m_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1 chk("t3_stall_ready", 64'(req_ready), 0);
      tick();
      chk("t3_stall_data", 64'(m_data), 32'hB000_0001);
      chk("t3_stall_valid", 64'(m_valid), 1);
      chk("t3_stall_busy", 64'(busy), 1);
    end
    m_ready = 1'b1;
    #1 chk("t3_resume_ready", 64'(req_ready), 4'b0010);
    tick();
    chk("t3_b2", 64'(m_data), 32'hB000_0002);
    set_lane(1, 32'hB000_0003, 1'b1);
    tick();
    req_valid = 4'b0000;
    chk("t3_b3", 64'(m_data), 32'hB000_0003);
    chk("t3_b3_last", 64'(m_last), 1);
    tick();
    chk("t3_no_dup", 64'(m_valid), 0);

    // Requester 0 packet locked while requester 3 waits; requester 0 goes quiet mid-packet.
    req_valid = 4'b0001; set_lane(0, 32'hC000_0001, 1'b0);
    tick();
    chk("t4_sel0", 64'(sel), 0);
    req_valid = 4'b1001; set_lane(3, 32'h3333_0001, 1'b1);
    tick();
    chk("t4_b1", 64'(m_data), 32'hC000_0001);
    set_lane(0, 32'hC000_0002, 1'b1); req_valid = 4'b1000;
    for (int c = 0; c < 2; c++) begin
      #1 chk("t4_gap_ready", 64'(req_ready), 4'b0001);
      tick();
      chk("t4_gap_sel", 64'(sel), 0);
      chk("t4_gap_busy", 64'(busy), 1);
      chk("t4_gap_wdog", 64'(wdog_err), 0);
    end
    chk("t4_gap_empty", 64'(m_valid), 0);
    req_valid = 4'b1001;
    tick();
    req_valid = 4'b1000;
    chk("t4_b2", 64'(m_data), 32'hC000_0002);
    chk("t4_b2_last", 64'(m_last), 1);
    chk("t4_idle", 64'(busy), 0);
    tick();
    chk("t4_sel3", 64'(sel), 3);
    tick();
    req_valid = 4'b0000;
    chk("t4_r3_data", 64'(m_data), 32'h3333_0001);
    tick();

    // Asynchronous reset in the middle of requester 2's packet.
    req_valid = 4'b0100; set_lane(2, 32'hD000_0001, 1'b0); set_lane(0, 32'hE000_0000, 1'b1);
    tick();
    chk("t5_sel2", 64'(sel), 2);
    tick();
    chk("t5_b1", 64'(m_data), 32'hD000_0001);
    req_valid = 4'b0101;
    #3 rst_n = 1'b0;
    #1;
    chk("t5_rst_sel", 64'(sel), 0);
    chk("t5_rst_busy", 64'(busy), 0);
    chk("t5_rst_valid", 64'(m_valid), 0);
    chk("t5_rst_data", 64'(m_data), 0);
    chk("t5_rst_ready", 64'(req_ready), 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_after_sel", 64'(sel), 0);
    chk("t5_after_busy", 64'(busy), 1);
    req_valid = 4'b0000;
    tick(); tick();

`ifdef MUX_ARB_WATCHDOG_EN
    // Requester 1 falls silent after beat 1; watchdog aborts after 4 quiet cycles.
    rst_n = 1'b0; tick(); rst_n = 1'b1; tick();
    req_valid = 4'b0010; set_lane(1, 32'hF000_0001, 1'b0);
    tick();
    chk("t6_sel1", 64'(sel), 1);
    tick();
    req_valid = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("t6_wdog_quiet", 64'(wdog_err), 0);
      chk("t6_busy_hold", 64'(busy), 1);
    end
    tick();
    chk("t6_wdog_pulse", 64'(wdog_err), 1);
    chk("t6_wdog_idle", 64'(busy), 0);
    chk("t6_data_kept", 64'(m_data), 32'hF000_0001);
    req_valid = 4'b0110; set_lane(2, 32'hF000_0002, 1'b1);
    tick();
    chk("t6_wdog_clear", 64'(wdog_err), 0);
    chk("t6_next_sel", 64'(sel), 2);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    bad++;
    $display("FAIL timeout total=%0d bad=%0d", total, bad);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mux4_rr_arbiter.md
Name: mux4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit 4:1 select datapath among four packet requesters.
- Drives the mux select `sel` and locks the grant for a whole packet (beats up to and including `last`).
- Lands each accepted beat in a single-entry registered output stage with valid/ready handshake.
- Sits between four producer ports and one downstream consumer.

Parameters:
- DW, 32, data width per requester and output.
- WDOG_CYCLES, 16, stall limit for the optional watchdog (only used when the macro is defined).

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  4  per-requester beat valid.
- req_data  in  4*DW  requester i data on bits [i*DW +: DW].
- req_last  in  4  per-requester end-of-packet flag.
- req_ready  out  4  per-requester beat accept; at most one bit high.
- sel  out  2  current grant index; drives the 4:1 select.
- busy  out  1  high while a packet grant is held.
- m_valid  out  1  output register holds a beat.
- m_data  out  DW  registered output data.
- m_last  out  1  registered last flag.
- m_ready  in  1  downstream accept.
- wdog_err  out  1  one-cycle abort pulse; tied 0 when the watchdog is compiled out.

Behaviour:
- Clocking and reset: single clock `clk`; asynchronous, active-low reset `rst_n`.
- Reset values:
  - state=IDLE, sel=0, busy=0, ptr=0.
  - m_valid=0, m_data=0, m_last=0, req_ready=0, wdog_err=0.
- State IDLE:
  - req_ready=0.
  - If any req_valid is high, pick the winner by search order ptr, ptr+1, ..., ptr+3 (mod 4).
  - Register sel=winner, busy=1, go to GRANT.
  - If no req_valid is high, stay in IDLE.
- State GRANT:
  - req_ready[sel] = can_load, where can_load = ~m_valid | m_ready. All other req_ready bits are 0.
  - A beat transfers when req_valid[sel] & req_ready[sel]. On transfer, load m_data = req_data[sel], m_last = req_last[sel], m_valid=1.
  - If the transferred beat has last=1: go to IDLE next cycle, busy=0, ptr=sel+1 (2-bit wrap, so 3 -> 0). sel holds its value.
- Output register:
  - m_valid clears on m_valid & m_ready when no new load happens in the same cycle.
  - Simultaneous drain and load keeps m_valid=1 with the new data (full throughput, one beat per cycle).
- Latency:
  - Arbitration costs one cycle. From req_valid rising in IDLE at cycle 0: grant at edge 1, first beat accepted at edge 2, m_valid high after edge 2.
  - Back-to-back packets have a one-cycle IDLE bubble between them.
- Boundary conditions:
  - Downstream stall (m_ready=0 with m_valid=1): req_ready=0, no data loss, state held.
  - Granted requester deasserts req_valid mid-packet: grant stays locked; no other requester is served.
  - Requests from other ports arriving during GRANT are ignored until IDLE.
  - A single-beat packet (last=1 on the first beat) is legal.
  - Reset asserted mid-packet: immediate return to reset values; the partial packet is dropped.
  - Requester data and last must stay stable while valid=1 and ready=0 (requester obligation; checked by assertion in the bench).

Optional Feature:
- MUX_ARB_WATCHDOG_EN defined:
  - In GRANT, count consecutive cycles with req_valid[sel]=0.
  - The count resets on any cycle with req_valid[sel]=1.
  - When the count reaches WDOG_CYCLES: pulse wdog_err for 1 cycle, go to IDLE, set ptr=sel+1. The output register is untouched.
- MUX_ARB_WATCHDOG_EN undefined:
  - No counter logic; wdog_err tied 0; the grant is held indefinitely.

Test Plan:
- Reset, then req_valid=4'b0100, 2-beat packet 0xAAAA0001/0xAAAA0002 (last on beat 2), m_ready=1 -> sel=2 after edge 1; m_data 0xAAAA0001 then 0xAAAA0002 with m_last=1; busy drops; ptr=3.
- All four requesters always valid with single-beat packets, data=0x1000_000i -> grant order 0,1,2,3,0, one beat per two cycles, req_ready one-hot.
- Requester 1 sends a 3-beat packet with m_ready=0 for 5 cycles mid-packet -> req_ready[1]=0 during the stall, m_data held, all 3 beats delivered in order, no duplicates.
- Requester 0 packet in flight while requester 3 asserts valid -> requester 3 is not served until requester 0's last beat; then sel=3 after one IDLE cycle.
- Assert rst_n=0 asynchronously mid-beat of requester 2's packet -> all outputs return to reset values before the next clk edge; after release, requester 0 wins first.
- MUX_ARB_WATCHDOG_EN with WDOG_CYCLES=4: granted requester 1 drops valid after beat 1 -> wdog_err pulses on the 4th stalled cycle, FSM returns to IDLE, next grant goes to requester 2 when 1 and 2 both request.
